// File: rtl/microseq_pkg.sv
// -----------------------------------------------------------------------------
// microseq_pkg
//   Shared definitions for the microseq_p microprogram sequencer (Am2910-style).
//   - opcode_e : the sixteen 4-bit instruction encodings presented on I
//   - src_e    : which external address source is enabled (PL / MAP / VECT)
//   - pass_f   : condition-test helper, active-low CC gated by active-low CCEN
// -----------------------------------------------------------------------------
package microseq_pkg;

    typedef enum logic [3:0] {
        OP_JZ   = 4'h0,  // jump to zero, clear stack
        OP_CJS  = 4'h1,  // conditional jump to subroutine (D)
        OP_JMAP = 4'h2,  // jump to map address (D), MAP enabled
        OP_CJP  = 4'h3,  // conditional jump pipeline (D)
        OP_PUSH = 4'h4,  // push uPC, conditionally load counter
        OP_JSRP = 4'h5,  // conditional subroutine call via R or D
        OP_CJV  = 4'h6,  // conditional jump vector (D), VECT enabled
        OP_JRP  = 4'h7,  // conditional jump via R or D
        OP_RFCT = 4'h8,  // repeat loop from stack while counter != 0
        OP_RPCT = 4'h9,  // repeat pipeline address while counter != 0
        OP_CRTN = 4'hA,  // conditional return
        OP_CJPP = 4'hB,  // conditional jump and pop
        OP_LDCT = 4'hC,  // load counter and continue
        OP_LOOP = 4'hD,  // test end of loop
        OP_CONT = 4'hE,  // continue
        OP_TWB  = 4'hF   // three-way branch
    } opcode_e;

    typedef enum logic [1:0] {
        SRC_PL   = 2'd0,
        SRC_MAP  = 2'd1,
        SRC_VECT = 2'd2
    } src_e;

    // The test passes when the condition is disabled (CCEN high) or when the
    // active-low condition code is asserted (CC low).
    function automatic logic pass_f(input logic cc, input logic ccen);
        return ccen | ~cc;
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// -----------------------------------------------------------------------------
// microseq_stack
//   LIFO used for subroutine return addresses and loop starts.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset (SP -> 0)
//     push, pop       one-cycle requests; never asserted together by the top
//     clear           empties the stack (SP -> 0); wins over push/pop
//     push_data       value written on an accepted push
//     tos             top of stack, 0 while empty
//     full_n, empty_n active-low status flags
//     push_ignored    (MICROSEQ_STKERR_EN only) push requested while full
//     pop_ignored     (MICROSEQ_STKERR_EN only) pop requested while empty
//   A push while full and a pop while empty leave SP and contents unchanged.
//   Storage is not reset; only SP is.
// -----------------------------------------------------------------------------
module microseq_stack #(
    parameter int AW = 12,
    parameter int SD = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] tos,
    output logic          full_n,
    output logic          empty_n
`ifdef MICROSEQ_STKERR_EN
    ,
    output logic          push_ignored,
    output logic          pop_ignored
`endif
);

    localparam int SPW = $clog2(SD + 1);
    // Storage is rounded up to a power of two so the SP-derived index is
    // exactly as wide as the array needs; entries at SD and above are unused.
    localparam int DEPTH = 1 << SPW;
    localparam logic [SPW-1:0] SP_MAX = SPW'(SD);

    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [SPW-1:0] top_idx;
    logic [AW-1:0]  mem_q [DEPTH];
    logic           is_full;
    logic           is_empty;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        is_full  = (sp_q == SP_MAX);
        is_empty = (sp_q == '0);
        do_push  = push & ~clear & ~is_full;
        do_pop   = pop  & ~clear & ~is_empty;
        top_idx  = sp_q - 1'b1;

        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (do_push) begin
            sp_d = sp_q + 1'b1;
        end else if (do_pop) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_q] <= push_data;
        end
    end

    assign tos     = is_empty ? '0 : mem_q[top_idx];
    assign full_n  = ~is_full;
    assign empty_n = ~is_empty;

`ifdef MICROSEQ_STKERR_EN
    assign push_ignored = push & ~clear & is_full;
    assign pop_ignored  = pop  & ~clear & is_empty;
`endif

endmodule

// File: rtl/microseq_p.sv
// -----------------------------------------------------------------------------
// microseq_p
//   Am2910-style microprogram sequencer: selects the next microaddress Y from
//   D, uPC, the register/counter R or the stack top, under control of the
//   4-bit instruction I and the condition test.
//   Parameters: AW address/counter width (4..16), SD stack depth (2..16).
//   Ports:
//     CP     clock, rising edge
//     RESET  asynchronous active-high reset
//     I      instruction (opcode_e)
//     D      direct branch address / counter load data
//     CC     condition code, active low;  CCEN condition enable, active low
//     RLD    load R from D, active low, overrides any other R update
//     CI     carry into the uPC incrementer (uPC <= Y + CI)
//     OE     output enable for Y, active low (Y high-Z when high)
//     Y      next microaddress (combinational)
//     FULL, EMPTY     stack status, active low
//     PL, MAP, VECT   source enables, active low, exactly one low
//     STKERR          present only with MICROSEQ_STKERR_EN: sticky flag for
//                     an ignored push/pop, cleared by RESET or JZ
//   Optional feature macro: MICROSEQ_STKERR_EN
// -----------------------------------------------------------------------------
module microseq_p
    import microseq_pkg::*;
#(
    parameter int AW = 12,
    parameter int SD = 5
) (
    input  logic          CP,
    input  logic          RESET,
    input  logic [3:0]    I,
    input  logic [AW-1:0] D,
    input  logic          CC,
    input  logic          CCEN,
    input  logic          RLD,
    input  logic          CI,
    input  logic          OE,
    output logic [AW-1:0] Y,
    output logic          FULL,
    output logic          EMPTY,
    output logic          PL,
    output logic          MAP,
    output logic          VECT
`ifdef MICROSEQ_STKERR_EN
    ,
    output logic          STKERR
`endif
);

    opcode_e       op;
    src_e          src;
    logic          pass;
    logic          r_nz;
    logic          push;
    logic          pop;
    logic          clear;
    logic [AW-1:0] tos;
    logic [AW-1:0] y_int;
    logic [AW-1:0] upc_q;
    logic [AW-1:0] upc_d;
    logic [AW-1:0] r_q;
    logic [AW-1:0] r_d;

    assign op   = opcode_e'(I);
    assign pass = pass_f(CC, CCEN);
    assign r_nz = (r_q != '0);

    // Instruction decode: next address, stack action, counter action.
    always_comb begin
        y_int = upc_q;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        r_d   = r_q;
        src   = SRC_PL;

        unique case (op)
            OP_JZ: begin
                y_int = '0;
                clear = 1'b1;
            end
            OP_CJS: begin
                if (pass) begin
                    y_int = D;
                    push  = 1'b1;
                end
            end
            OP_JMAP: begin
                y_int = D;
                src   = SRC_MAP;
            end
            OP_CJP: begin
                if (pass) y_int = D;
            end
            OP_PUSH: begin
                push = 1'b1;
                if (pass) r_d = D;
            end
            OP_JSRP: begin
                push  = 1'b1;
                y_int = pass ? D : r_q;
            end
            OP_CJV: begin
                if (pass) y_int = D;
                src = SRC_VECT;
            end
            OP_JRP: begin
                y_int = pass ? D : r_q;
            end
            OP_RFCT: begin
                // Counter exhausted: fall through and discard the loop start.
                if (r_nz) begin
                    y_int = tos;
                    r_d   = r_q - 1'b1;
                end else begin
                    pop = 1'b1;
                end
            end
            OP_RPCT: begin
                if (r_nz) begin
                    y_int = D;
                    r_d   = r_q - 1'b1;
                end
            end
            OP_CRTN: begin
                if (pass) begin
                    y_int = tos;
                    pop   = 1'b1;
                end
            end
            OP_CJPP: begin
                if (pass) begin
                    y_int = D;
                    pop   = 1'b1;
                end
            end
            OP_LDCT: begin
                r_d = D;
            end
            OP_LOOP: begin
                if (pass) begin
                    pop = 1'b1;
                end else begin
                    y_int = tos;
                end
            end
            OP_CONT: begin
                y_int = upc_q;
            end
            OP_TWB: begin
                // Only "counter running and test failed" keeps the loop
                // entry; every other outcome leaves the loop and pops it.
                if (r_nz && !pass) begin
                    y_int = tos;
                    r_d   = r_q - 1'b1;
                end else if (!r_nz && !pass) begin
                    y_int = D;
                    pop   = 1'b1;
                end else begin
                    pop   = 1'b1;
                end
            end
            default: begin
                y_int = upc_q;
            end
        endcase

        // External load of R beats decrement and instruction loads.
        if (!RLD) r_d = D;

        upc_d = y_int + {{(AW-1){1'b0}}, CI};
    end

    always_ff @(posedge CP or posedge RESET) begin
        if (RESET) begin
            upc_q <= '0;
            r_q   <= '0;
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
        end
    end

    logic full_n;
    logic empty_n;

`ifdef MICROSEQ_STKERR_EN
    logic push_ignored;
    logic pop_ignored;
    logic stkerr_q;
    logic stkerr_d;
`endif

    microseq_stack #(
        .AW (AW),
        .SD (SD)
    ) u_stack (
        .clk          (CP),
        .rst          (RESET),
        .push         (push),
        .pop          (pop),
        .clear        (clear),
        .push_data    (upc_q),
        .tos          (tos),
        .full_n       (full_n),
        .empty_n      (empty_n)
`ifdef MICROSEQ_STKERR_EN
        ,
        .push_ignored (push_ignored),
        .pop_ignored  (pop_ignored)
`endif
    );

`ifdef MICROSEQ_STKERR_EN
    // JZ cannot itself push or pop, so its clear never races a new error.
    always_comb begin
        stkerr_d = stkerr_q;
        if (op == OP_JZ) begin
            stkerr_d = 1'b0;
        end else if (push_ignored || pop_ignored) begin
            stkerr_d = 1'b1;
        end
    end

    always_ff @(posedge CP or posedge RESET) begin
        if (RESET) begin
            stkerr_q <= 1'b0;
        end else begin
            stkerr_q <= stkerr_d;
        end
    end

    assign STKERR = stkerr_q;
`endif

    // While RESET is held the outputs show the reset address with PL enabled.
    assign Y     = OE ? {AW{1'bz}} : (RESET ? '0 : y_int);
    assign PL    = ~(RESET || (src == SRC_PL));
    assign MAP   = RESET || (src != SRC_MAP);
    assign VECT  = RESET || (src != SRC_VECT);
    assign FULL  = full_n;
    assign EMPTY = empty_n;

endmodule

// File: doc/microseq_p.md
MICROSEQ_P -- requirements
Module: microseq_p

Interface
REQ-001 SHALL have parameter AW, default 12: address, counter and D/Y width in bits (range 4..16).
REQ-002 SHALL have parameter SD, default 5: stack depth in entries (range 2..16).
REQ-003 SHALL have port CP  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port I  input  4  instruction select (0x0..0xF, Am2910 encoding).
REQ-006 SHALL have port D  input  AW  direct branch address / counter load data.
REQ-007 SHALL have port CC  input  1  condition code, active low (0 = true).
REQ-008 SHALL have port CCEN  input  1  condition enable, active low; when high, the test always passes.
REQ-009 SHALL have port RLD  input  1  register load, active low; loads R from D.
REQ-010 SHALL have port CI  input  1  carry into the uPC incrementer.
REQ-011 SHALL have port OE  input  1  output enable, active low; when high, Y is high-Z.
REQ-012 SHALL have ports Y  output  AW  next microaddress; FULL, EMPTY  output  1  stack-status flags, active low.
REQ-013 SHALL have ports PL, MAP, VECT  output  1  source enables, active low, exactly one low per cycle.

Function
REQ-014 SHALL define PASS as (CCEN | ~CC).
- PASS SHALL be combinational.
- Y SHALL be combinational from I, PASS, D, uPC, R, TOS and R==0.
REQ-015 SHALL update uPC <= Y + CI on every clock, truncated to AW bits (wrap 2^AW-1 -> 0).
REQ-016 SHALL implement instructions 0x0-0x7 as follows:
- 0 JZ: Y=0; SP cleared.
- 1 CJS: PASS: Y=D and push uPC; else Y=uPC.
- 2 JMAP: Y=D; MAP low.
- 3 CJP: Y = PASS ? D : uPC.
- 4 PUSH: push uPC; Y=uPC; PASS loads R from D.
- 5 JSRP: push uPC; Y = PASS ? D : R.
- 6 CJV: Y = PASS ? D : uPC; VECT low.
- 7 JRP: Y = PASS ? D : R.
REQ-017 SHALL implement instructions 0x8-0xF as follows:
- 8 RFCT: R!=0: Y=TOS, R-1; else Y=uPC and pop.
- 9 RPCT: R!=0: Y=D, R-1; else Y=uPC.
- A CRTN: PASS: Y=TOS and pop; else Y=uPC.
- B CJPP: PASS: Y=D and pop; else Y=uPC.
- C LDCT: R<=D; Y=uPC.
- D LOOP: PASS: Y=uPC and pop; else Y=TOS.
- E CONT: Y=uPC.
- F TWB: R!=0 & fail: Y=TOS, R-1. R!=0 & PASS: Y=uPC, pop. R==0 & fail: Y=D, pop. R==0 & PASS: Y=uPC, pop.
REQ-018 SHALL drive PL low for every instruction except JMAP (MAP low) and CJV (VECT low).
REQ-019 SHALL give RLD=0 priority over any decrement or instruction load of R in the same cycle.
REQ-020 SHALL define the stack pointer SP, range 0..SD:
- TOS = stack[SP-1]; TOS = 0 when SP=0.
- FULL low when SP=SD; EMPTY low when SP=0.
REQ-021 SHALL ignore a push when SP=SD: stack and SP unchanged.
REQ-022 SHALL ignore a pop when SP=0: SP stays 0.
REQ-023 SHALL make JZ clear SP regardless of PASS.
REQ-024 SHALL never decrement R below 0; the R==0 branch is taken instead.

Reset
REQ-025 SHALL, while RESET is high, force:
- uPC=0, R=0, SP=0, stack contents don't-care;
- Y=0 (if OE low), PL low, MAP high, VECT high, FULL high, EMPTY low.
REQ-026 SHALL start executing on the first rising CP edge after RESET falls; RESET asserted mid-instruction SHALL abort that instruction without completing any push or pop.

Configuration
REQ-027 SHALL, when macro MICROSEQ_STKERR_EN is defined, add output STKERR (1 bit, active high):
- STKERR is set sticky by an ignored push (REQ-021) or pop (REQ-022);
- STKERR is cleared only by RESET or by JZ.
REQ-028 SHALL, without MICROSEQ_STKERR_EN, have no STKERR port and no error logic.

Structure
REQ-029 SHALL place the 16 instruction opcode constants and a PASS helper function in package microseq_pkg.
REQ-030 SHALL implement the LIFO (storage, SP, FULL/EMPTY, push/pop/clear) as sub-module microseq_stack, parameterised by AW and SD.

Verification
REQ-031 Reset: RESET=1, I=0xE, OE=0 -> Y=0, PL=0, EMPTY=0, FULL=1; after release with CI=1, Y counts 1,2,3 on successive edges.
REQ-032 Counter loop: PUSH with CC=0, CCEN=0, D=2, then RFCT -> Y returns to TOS twice, then falls through with a pop; EMPTY=0 afterwards.
REQ-033 Subroutine: CJS with D=0x100 and PASS, then CONT, then CRTN with PASS -> Y=0x100, then 0x101, then return address+1 sequence; SP back to 0.
REQ-034 Overflow: SD=5, six consecutive PUSH -> FULL=0 after the fifth; the sixth is ignored; with MICROSEQ_STKERR_EN, STKERR=1 until JZ.
REQ-035 Map/vector and wrap: JMAP with D=0xABC -> MAP=0, PL=1, Y=0xABC; CJV -> VECT=0; uPC=0xFFF with CI=1 and CONT -> Y=0x000 next cycle.
REQ-036 OE and width: OE=1 -> Y high-Z; repeat REQ-031 and REQ-033 with AW=8, SD=2 -> Y and D truncated to 8 bits and FULL=0 after two pushes.
